// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled up-counter timer with one-shot/periodic modes,
// one-cycle tick on expiry and a sticky interrupt flag.
module timer_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     period,
  input  logic [PSC_WIDTH-1:0] prescale,
  input  logic                 irq_clr,
  output logic                 busy,
  output logic [WIDTH-1:0]     cnt,
  output logic                 tick,
  output logic                 irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]     per_q, per_d;
  logic [PSC_WIDTH-1:0] pre_q, pre_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 tick_q, tick_d;
  logic                 irq_q, irq_d;

  logic                 run;
  logic                 step;
  logic                 at_end;
  logic                 expire;

  // Counting qualifiers: a step happens when the prescaler wraps,
  // and an expiry when that step lands on the terminal count.
  always_comb begin
    run    = (state_q == RUN);
    step   = run && (psc_q == pre_q);
    at_end = (cnt_q == per_q);
    expire = step && at_end;
  end

  // Next-state: stop beats start, start beats counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    psc_d   = psc_q;
    per_d   = per_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    irq_d   = irq_q & ~irq_clr;
    if (stop) begin
      if (run) begin
        state_d = IDLE;
      end
    end else if (start) begin
      per_d   = period;
      pre_d   = prescale;
      mode_d  = mode;
      cnt_d   = '0;
      psc_d   = '0;
      state_d = RUN;
    end else if (run) begin
      if (step) begin
        psc_d = '0;
        if (expire) begin
          tick_d = 1'b1;
          irq_d  = 1'b1;
          unique case (1'b1)
            mode_q:  cnt_d   = '0;
            !mode_q: state_d = DONE;
          endcase
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        psc_d = psc_q + PSC_WIDTH'(1);
      end
    end
    busy_d = (state_d == RUN);
  end

  // State and registered outputs; rst clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      psc_q   <= '0;
      per_q   <= '0;
      pre_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      irq_q   <= irq_d;
    end
  end

  assign busy = busy_q;
  assign cnt  = cnt_q;
  assign tick = tick_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scoreboard bench for timer_ctrl.
// Expected outputs are queued with the stimulus and checked after each edge.
module tb_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] period;
  logic [7:0] prescale;
  logic       irq_clr;
  logic       busy;
  logic [7:0] cnt;
  logic       tick;
  logic       irq;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic       busy;
    logic       tick;
    logic       irq;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_tick   = 0;

  timer_ctrl #(.WIDTH(8), .PSC_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .prescale (prescale),
    .irq_clr  (irq_clr),
    .busy     (busy),
    .cnt      (cnt),
    .tick     (tick),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int c, bit b, bit t, bit i);
    exp_t e;
    e.tag  = tag;
    e.cnt  = c[7:0];
    e.busy = b;
    e.tick = t;
    e.irq  = i;
    q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk({e.tag, ".cnt"},  32'(cnt),  32'(e.cnt));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
      chk({e.tag, ".tick"}, 32'(tick), 32'(e.tick));
      chk({e.tag, ".irq"},  32'(irq),  32'(e.irq));
    end
  endtask

  task automatic cyc(string tag, int c, bit b, bit t, bit i);
    push(tag, c, b, t, i);
    @(posedge clk);
    #1;
    check_now();
    if (tick === 1'b1) n_tick++;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    mode     = 1'b0;
    period   = 8'd0;
    prescale = 8'd0;
    irq_clr  = 1'b0;
    #2;
    push("rst0", 0, 0, 0, 0);
    check_now();
    cyc("rst1", 0, 0, 0, 0);
    cyc("rst2", 0, 0, 0, 0);
    rst = 1'b0;
    cyc("idle", 0, 0, 0, 0);

    // 1: one-shot period=3 prescale=0
    start = 1'b1; mode = 1'b0; period = 8'd3; prescale = 8'd0;
    cyc("os_e0", 0, 1, 0, 0);
    start = 1'b0;
    cyc("os_e1", 1, 1, 0, 0);
    cyc("os_e2", 2, 1, 0, 0);
    cyc("os_e3", 3, 1, 0, 0);
    cyc("os_e4", 3, 0, 1, 1);
    cyc("os_e5", 3, 0, 0, 1);
    cyc("os_e6", 3, 0, 0, 1);
    irq_clr = 1'b1;
    cyc("os_clr", 3, 0, 0, 0);
    irq_clr = 1'b0;

    // 2+4: periodic period=2 prescale=1, irq_clr collides at E12
    start = 1'b1; mode = 1'b1; period = 8'd2; prescale = 8'd1;
    n_tick = 0;
    for (int k = 0; k <= 18; k++) begin
      int  c;
      bit  t;
      bit  i;
      c = (k % 6) / 2;
      t = (k > 0) && (k % 6 == 0);
      i = ((k >= 6) && (k <= 12)) || (k == 18);
      irq_clr = (k == 12) || (k == 13);
      cyc($sformatf("per_%0d", k), c, 1, t, i);
      start = 1'b0;
    end
    irq_clr = 1'b0;
    chk("per_ticks", 32'(n_tick), 32'd3);

    // 3: stop and restart, period=5 prescale=0
    start = 1'b1; mode = 1'b1; period = 8'd5; prescale = 8'd0;
    cyc("sr_e0", 0, 1, 0, 1);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) cyc($sformatf("sr_%0d", k), k, 1, 0, 1);
    stop = 1'b1;
    cyc("sr_stop", 3, 0, 0, 1);
    stop = 1'b0;
    for (int k = 0; k < 10; k++) cyc($sformatf("sr_hold%0d", k), 3, 0, 0, 1);
    start = 1'b1;
    cyc("rs_e0", 0, 1, 0, 1);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) cyc($sformatf("rs_%0d", k), k, 1, 0, 1);
    cyc("rs_exp", 0, 1, 1, 1);
    cyc("rs_e7", 1, 1, 0, 1);
    start = 1'b1; stop = 1'b1;
    cyc("ss_both", 1, 0, 0, 1);
    start = 1'b0; stop = 1'b0;
    cyc("ss_idle", 1, 0, 0, 1);

    // 5: period=0 prescale=0 periodic, then one-shot reloads
    start = 1'b1; mode = 1'b1; period = 8'd0; prescale = 8'd0;
    cyc("z_e0", 0, 1, 0, 1);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) cyc($sformatf("z_%0d", k), 0, 1, 1, 1);
    start = 1'b1; mode = 1'b0; period = 8'd1;
    cyc("o1_e0", 0, 1, 0, 1);
    start = 1'b0;
    cyc("o1_e1", 1, 1, 0, 1);
    cyc("o1_exp", 1, 0, 1, 1);
    cyc("o1_done", 1, 0, 0, 1);
    start = 1'b1; period = 8'd7;
    cyc("o7_e0", 0, 1, 0, 1);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) cyc($sformatf("o7_%0d", k), k, 1, 0, 1);
    cyc("o7_exp", 7, 0, 1, 1);
    cyc("o7_done", 7, 0, 0, 1);

    // 6: asynchronous reset mid-count
    start = 1'b1; mode = 1'b1; period = 8'd9;
    cyc("ar_e0", 0, 1, 0, 1);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) cyc($sformatf("ar_%0d", k), k, 1, 0, 1);
    #2;
    rst   = 1'b1;
    start = 1'b1;
    #1;
    push("ar_async", 0, 0, 0, 0);
    check_now();
    cyc("ar_hold1", 0, 0, 0, 0);
    cyc("ar_hold2", 0, 0, 0, 0);
    rst   = 1'b0;
    start = 1'b0;
    cyc("ar_rel1", 0, 0, 0, 0);
    cyc("ar_rel2", 0, 0, 0, 0);
    start = 1'b1;
    cyc("ar_go", 0, 1, 0, 0);
    start = 1'b0;
    cyc("ar_go1", 1, 1, 0, 0);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable timer controller that sequences a prescaler and a WIDTH-bit up-counter through start/stop/expiry.
- Counts modulo a programmable period in one-shot or periodic mode, with a one-cycle tick and a sticky interrupt flag.
- Sits beside the CPU core as the timer peripheral.
- Control inputs are driven by the register/bus decode logic.

Parameters:
WIDTH, 8, counter and period width
PSC_WIDTH, 8, prescaler and prescale-value width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  start/restart request, level-sampled each clk
stop  input  1  stop request, level-sampled each clk
mode  input  1  0 = one-shot, 1 = periodic; sampled with start
period  input  WIDTH  terminal count value; sampled with start
prescale  input  PSC_WIDTH  counter advances every prescale+1 clocks; sampled with start
irq_clr  input  1  clears irq
busy  output  1  high while in RUN
cnt  output  WIDTH  current count
tick  output  1  one-cycle pulse per expiry
irq  output  1  sticky expiry flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- While rst=1: state=IDLE, cnt=0, internal prescaler=0, busy=0, tick=0, irq=0, latched period/prescale/mode=0. All inputs are ignored.
- Reset asserted mid-run aborts immediately. No expiry is reported.
- States: IDLE, RUN, DONE. busy=1 only in RUN.
- Command priority per edge: stop > start > counting.
- start=1, stop=0, any state:
  - Latch period, prescale and mode.
  - Clear cnt and the prescaler.
  - Go to RUN.
  - start while in RUN is a restart; no tick is generated for the aborted period.
- stop=1 in RUN: go to IDLE. cnt holds its value and the prescaler holds. In IDLE or DONE, stop has no effect.
- RUN, step condition:
  - If prescaler == latched prescale: step=1 and the prescaler is cleared.
  - Otherwise the prescaler increments and step=0.
  - prescale=0 gives step every cycle.
- RUN, step=1 and cnt != latched period: cnt <= cnt+1.
- RUN, step=1 and cnt == latched period: expiry edge.
  - tick <= 1 for exactly the following cycle; irq <= 1.
  - Periodic: cnt <= 0 and stay in RUN.
  - One-shot: cnt holds at period and the state goes to DONE.
- Expiry interval: (period+1)*(prescale+1) clocks.
  - period=0, prescale=0, periodic gives tick=1 continuously.
- cnt never exceeds the latched period, so no WIDTH overflow or wrap is possible.
- tick is registered and is low in every cycle not immediately following an expiry edge.
- DONE: cnt frozen, busy=0. Leaves only via start, or rst.
- irq_clr=1 clears irq on the edge. If the same edge is an expiry edge, set wins and irq stays 1.
- Changes to period, prescale or mode while in RUN have no effect until the next start.
- All outputs are registered. There are no combinational input-to-output paths.

Test Plan:
1. One-shot (mode=0, period=3, prescale=0), start pulsed at edge E0:
   - cnt=0,1,2,3 after E0..E3; expiry at E4.
   - tick=1 only in the cycle after E4; busy 1→0 at E4.
   - cnt stays at 3; irq=1 and stays high.
2. Periodic (mode=1, period=2, prescale=1), run 18 cycles after start:
   - Exactly 3 tick pulses, spaced 6 cycles apart.
   - cnt sequence 0,0,1,1,2,2 repeating; busy stays 1.
3. Stop and restart:
   - Periodic period=5, prescale=0. stop when cnt=3: state IDLE, busy=0, cnt holds 3 for 10 cycles, no tick.
   - Then start: cnt=0 next cycle; first tick 6 cycles after start.
   - Also start with stop=1 on the same edge → IDLE, not restarted.
4. Interrupt collision: irq_clr held high on the expiry edge → irq=1 afterwards; irq_clr on the next edge → irq=0.
5. Edge case (period=0, prescale=0, periodic): tick=1 every cycle from one cycle after the first expiry; cnt=0 constant.
   - Reload in one-shot with new period=7 from DONE restarts cleanly.
6. Async reset: assert rst mid-count (cnt=4, irq=1, busy=1) between clock edges.
   - All outputs read 0 immediately, before the next clk edge.
   - start held during reset is ignored; after release, start is required to resume.
